// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Widest legal word; narrower words are zero-padded, which leaves XOR unchanged.
    localparam int MAX_DATA_BITS = 9;

    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input logic [1:0] mode);
        return (mode == PAR_ODD) ? ~(^data) : (^data);
    endfunction

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO; a push into a full FIFO is dropped even if a pop happens alongside.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = DEPTH[CNT_W-1:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// Buffered UART transmitter: start, LSB-first data, optional parity, 1-2 stop symbols per tx_en tick.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 tx_en,
    input  logic [1:0]           parity_mode,
    output logic                 tx,
    output logic                 busy,
    output logic                 wr_ready,
    output logic [CNT_W-1:0]     fifo_count,
    output logic                 overflow,
    output logic                 frame_done
);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = DATA_BITS[IDX_W-1:0];
    localparam logic [IDX_W-1:0] IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]       STOP_LAST = STOP_BITS[1:0];

    tx_state_t              state, state_n;
    logic [DATA_BITS-1:0]   shreg, shreg_n, fifo_dout;
    logic [IDX_W-1:0]       idx, idx_n;
    logic [1:0]             stop_cnt, stop_n;
    logic                   par_en, par_en_n, par_bit, par_bit_n;
    logic                   tx_q, tx_n;
    logic                   load, fifo_full, fifo_empty;
    logic [MAX_DATA_BITS-1:0] par_word;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .pop   (load),
        .din   (data_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tx       = tx_q;
    assign busy     = (state != IDLE);
    assign wr_ready = !fifo_full;
    assign overflow = wr_en && fifo_full;

    always_comb begin
        par_word = '0;
        par_word[DATA_BITS-1:0] = fifo_dout;
    end

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        idx_n      = idx;
        stop_n     = stop_cnt;
        par_en_n   = par_en;
        par_bit_n  = par_bit;
        tx_n       = tx_q;
        load       = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                load = tx_en && !fifo_empty;
            end
            START: if (tx_en) begin
                tx_n    = shreg[0];
                shreg_n = shreg >> 1;
                idx_n   = IDX_ONE;
                state_n = DATA;
            end
            DATA: if (tx_en) begin
                if (idx < IDX_LAST) begin
                    tx_n    = shreg[0];
                    shreg_n = shreg >> 1;
                    idx_n   = idx + 1'b1;
                end else if (par_en) begin
                    tx_n    = par_bit;
                    state_n = PARITY;
                end else begin
                    tx_n    = 1'b1;
                    stop_n  = 2'd1;
                    state_n = STOP;
                end
            end
            PARITY: if (tx_en) begin
                tx_n    = 1'b1;
                stop_n  = 2'd1;
                state_n = STOP;
            end
            STOP: if (tx_en) begin
                if (stop_cnt < STOP_LAST) begin
                    tx_n   = 1'b1;
                    stop_n = stop_cnt + 1'b1;
                end else begin
                    frame_done = 1'b1;
                    // Chain straight into the next start bit when more words wait.
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        tx_n    = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                tx_n    = 1'b1;
                state_n = IDLE;
            end
        endcase
        // Parity mode is sampled once per frame so mid-frame changes apply to the next word.
        if (load) begin
            shreg_n   = fifo_dout;
            par_en_n  = parity_enabled(parity_mode);
            par_bit_n = calc_parity(par_word, parity_mode);
            tx_n      = 1'b0;
            state_n   = START;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            idx      <= '0;
            stop_cnt <= '0;
            par_en   <= 1'b0;
            par_bit  <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            idx      <= idx_n;
            stop_cnt <= stop_n;
            par_en   <= par_en_n;
            par_bit  <= par_bit_n;
            tx_q     <= tx_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench: 8-bit/1-stop/depth-4 instance plus a 5-bit/2-stop/depth-2 instance.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst, tx_en;
    logic       wr_en, wr_en_b;
    logic [7:0] data_in;
    logic [4:0] data_b;
    logic [1:0] pm, pm_b;

    logic       tx_a, busy_a, wr_ready_a, ov_a, fd_a;
    logic [2:0] cnt_a;
    logic       tx_b, busy_b, wr_ready_b, ov_b, fd_b;
    logic [1:0] cnt_b;

    logic       fd_a_s, fd_b_s, ov_a_s, ov_b_s, ov_first;
    int         cnt_first;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .tx_en(tx_en),
        .parity_mode(pm), .tx(tx_a), .busy(busy_a), .wr_ready(wr_ready_a),
        .fifo_count(cnt_a), .overflow(ov_a), .frame_done(fd_a)
    );

    uart_tx_frame #(.DATA_BITS(5), .STOP_BITS(2), .FIFO_DEPTH(2)) u_dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en_b), .data_in(data_b), .tx_en(tx_en),
        .parity_mode(pm_b), .tx(tx_b), .busy(busy_b), .wr_ready(wr_ready_b),
        .fifo_count(cnt_b), .overflow(ov_b), .frame_done(fd_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; inputs change just after posedge, pulses are sampled at negedge.
    task automatic cyc(input logic en);
        tx_en = en;
        @(negedge clk);
        fd_a_s = fd_a; fd_b_s = fd_b; ov_a_s = ov_a; ov_b_s = ov_b;
        @(posedge clk); #1;
        tx_en = 1'b0; wr_en = 1'b0; wr_en_b = 1'b0;
    endtask

    // Reference line sequence for one frame, bit i = symbol i.
    function automatic logic [15:0] frame_syms(input logic [8:0] d, input int db,
                                               input logic [1:0] pmode, input int ns,
                                               output int len);
        logic [15:0] s;
        int k;
        logic p;
        s = '1; k = 0; p = 1'b0;
        s[k] = 1'b0; k++;
        for (int i = 0; i < db; i++) begin s[k] = d[i]; p = p ^ d[i]; k++; end
        if (pmode == 2'b01)      begin s[k] = p;  k++; end
        else if (pmode == 2'b10) begin s[k] = ~p; k++; end
        for (int i = 0; i < ns; i++) begin s[k] = 1'b1; k++; end
        len = k;
        return s;
    endfunction

    task automatic run_frame(input logic sel, input logic [8:0] d, input int db,
                             input logic [1:0] pmode, input int ns, input logic fd_first,
                             input logic [1:0] pm_after, input int gap, input string tag);
        logic [15:0] syms;
        int n;
        syms = frame_syms(d, db, pmode, ns, n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1);
            if (i == 0) begin
                pm = pm_after;
                cnt_first = sel ? int'(cnt_b) : int'(cnt_a);
                ov_first  = sel ? ov_b_s : ov_a_s;
            end
            chk($sformatf("%s sym%0d", tag, i), sel ? tx_b : tx_a, syms[i]);
            chk($sformatf("%s fd%0d", tag, i), sel ? fd_b_s : fd_a_s, (i == 0) ? fd_first : 1'b0);
            chk($sformatf("%s busy%0d", tag, i), sel ? busy_b : busy_a, 1'b1);
            for (int g = 0; g < gap; g++) begin
                cyc(1'b0);
                chk($sformatf("%s hold%0d", tag, i), sel ? tx_b : tx_a, syms[i]);
            end
        end
    endtask

    task automatic end_frame(input logic sel, input string tag);
        cyc(1'b1);
        chk({tag, " done"}, sel ? fd_b_s : fd_a_s, 1'b1);
        chk({tag, " idle"}, sel ? busy_b : busy_a, 1'b0);
        chk({tag, " txhi"}, sel ? tx_b : tx_a, 1'b1);
    endtask

    logic [7:0] words [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    initial begin
        rst = 1'b1; tx_en = 1'b0; wr_en = 1'b0; wr_en_b = 1'b0;
        data_in = '0; data_b = '0; pm = 2'b00; pm_b = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst tx", tx_a, 1'b1);
        chk("rst busy", busy_a, 1'b0);
        chk("rst wr_ready", wr_ready_a, 1'b1);
        chk("rst count", cnt_a, 3'd0);
        chk("rst overflow", ov_a, 1'b0);
        chk("rst frame_done", fd_a, 1'b0);
        rst = 1'b0;

        // 0xA5, even parity, idle cycles between ticks must hold the line
        pm = 2'b01; wr_en = 1'b1; data_in = 8'hA5;
        cyc(1'b0);
        chk("a5 queued", cnt_a, 3'd1);
        chk("a5 not busy", busy_a, 1'b0);
        chk("a5 still idle", tx_a, 1'b1);
        chk("a5 no ovf", ov_a_s, 1'b0);
        run_frame(1'b0, 9'hA5, 8, 2'b01, 1, 1'b0, 2'b01, 1, "a5even");
        chk("a5 popped", cnt_first, 0);
        end_frame(1'b0, "a5even");

        // 0x00, odd parity gives a 1 parity symbol
        pm = 2'b10; wr_en = 1'b1; data_in = 8'h00;
        cyc(1'b0);
        run_frame(1'b0, 9'h000, 8, 2'b10, 1, 1'b0, 2'b10, 0, "zero_odd");
        end_frame(1'b0, "zero_odd");

        // fill past depth, overflow on the fifth word only
        pm = 2'b00;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; data_in = words[i];
            cyc(1'b0);
            chk($sformatf("fill ovf%0d", i), ov_a_s, (i == 4) ? 1'b1 : 1'b0);
        end
        chk("full count", cnt_a, 3'd4);
        chk("full wr_ready", wr_ready_a, 1'b0);
        cyc(1'b0);
        chk("ovf clears", ov_a_s, 1'b0);
        wr_en = 1'b1; data_in = 8'h66;
        run_frame(1'b0, 9'h011, 8, 2'b00, 1, 1'b0, 2'b00, 0, "b2b11");
        chk("full push+pop ovf", ov_first, 1'b1);
        chk("full push+pop count", cnt_first, 3);
        wr_en = 1'b1; data_in = 8'h77;
        run_frame(1'b0, 9'h022, 8, 2'b00, 1, 1'b1, 2'b00, 0, "b2b22");
        chk("push+pop ovf", ov_first, 1'b0);
        chk("push+pop count", cnt_first, 3);
        run_frame(1'b0, 9'h033, 8, 2'b00, 1, 1'b1, 2'b00, 0, "b2b33");
        chk("b2b33 count", cnt_first, 2);
        run_frame(1'b0, 9'h044, 8, 2'b00, 1, 1'b1, 2'b00, 0, "b2b44");
        chk("b2b44 count", cnt_first, 1);
        run_frame(1'b0, 9'h077, 8, 2'b00, 1, 1'b1, 2'b00, 0, "b2b77");
        chk("b2b77 count", cnt_first, 0);
        end_frame(1'b0, "b2b");

        // parity switched on mid-frame only affects the next word
        pm = 2'b00;
        wr_en = 1'b1; data_in = 8'h3C; cyc(1'b0);
        wr_en = 1'b1; data_in = 8'hC3; cyc(1'b0);
        run_frame(1'b0, 9'h03C, 8, 2'b00, 1, 1'b0, 2'b01, 0, "pm_none");
        run_frame(1'b0, 9'h0C3, 8, 2'b01, 1, 1'b1, 2'b01, 0, "pm_even");
        end_frame(1'b0, "pm_even");

        // reset in DATA of 0xFF with two words queued
        pm = 2'b00;
        wr_en = 1'b1; data_in = 8'hFF; cyc(1'b0);
        wr_en = 1'b1; data_in = 8'h12; cyc(1'b0);
        wr_en = 1'b1; data_in = 8'h34; cyc(1'b0);
        repeat (3) cyc(1'b1);
        chk("pre-rst count", cnt_a, 3'd2);
        chk("pre-rst busy", busy_a, 1'b1);
        rst = 1'b1; cyc(1'b0); rst = 1'b0;
        chk("mid-rst tx", tx_a, 1'b1);
        chk("mid-rst busy", busy_a, 1'b0);
        chk("mid-rst count", cnt_a, 3'd0);
        chk("mid-rst wr_ready", wr_ready_a, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1);
            chk($sformatf("post-rst tx%0d", i), tx_a, 1'b1);
            chk($sformatf("post-rst busy%0d", i), busy_a, 1'b0);
        end

        // reset while the line is low must release it
        wr_en = 1'b1; data_in = 8'h00; cyc(1'b0);
        cyc(1'b1); cyc(1'b1);
        chk("low pre-rst tx", tx_a, 1'b0);
        rst = 1'b1; cyc(1'b0); rst = 1'b0;
        chk("low rst tx", tx_a, 1'b1);
        chk("low rst busy", busy_a, 1'b0);

        // 5-bit/2-stop instance: tick in the write cycle must not start the frame
        pm_b = 2'b00; wr_en_b = 1'b1; data_b = 5'h1F;
        cyc(1'b1);
        chk("b same-cycle tx", tx_b, 1'b1);
        chk("b same-cycle busy", busy_b, 1'b0);
        chk("b same-cycle count", cnt_b, 2'd1);
        chk("b wr_ready", wr_ready_b, 1'b1);
        run_frame(1'b1, 9'h01F, 5, 2'b00, 2, 1'b0, 2'b00, 0, "b1f");
        end_frame(1'b1, "b1f");
        pm_b = 2'b10; wr_en_b = 1'b1; data_b = 5'h0A;
        cyc(1'b0);
        run_frame(1'b1, 9'h00A, 5, 2'b10, 2, 1'b0, 2'b00, 0, "b0a_odd");
        end_frame(1'b1, "b0a_odd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter: frames words of configurable width with optional even/odd parity and one or two stop bits, and buffers pending words in an internal FIFO so the producer can queue several bytes while a frame is in flight. It sits between the bus/register interface and the `tx` pin. One line symbol is emitted per `tx_en` tick, and `tx_en` comes from the shared baud generator. It is the next-generation replacement for the single-word transmitter, adds parity, multi-stop, buffering and error/status flags, and fixes reset-during-frame behaviour.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal range 5–9.
- `STOP_BITS`, 1: stop symbols per frame, 1 or 2.
- `FIFO_DEPTH`, 4: queued words, power of two, ≥2.
- `CNT_W`, $clog2(FIFO_DEPTH+1): width of `fifo_count`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `wr_en` in 1: push `data_in` into the FIFO this cycle.
- `data_in` in DATA_BITS: word to send, LSB transmitted first.
- `tx_en` in 1: baud tick, one-cycle pulse, one symbol per tick.
- `parity_mode` in 2: 00 none, 01 even, 10 odd, 11 none.
- `tx` out 1: serial line, idle high.
- `busy` out 1: a frame is in progress (state ≠ IDLE).
- `wr_ready` out 1: FIFO not full.
- `fifo_count` out CNT_W: words queued, excluding the frame in flight.
- `overflow` out 1: one-cycle pulse when `wr_en` is dropped because the FIFO is full.
- `frame_done` out 1: one-cycle pulse on the tick that ends the last stop symbol.

## Operation
- Reset: `tx`=1, state=IDLE, FIFO empty, `fifo_count`=0, `busy`=0, `wr_ready`=1, `overflow`=0, `frame_done`=0. Reset mid-frame aborts the frame at once. `tx` returns high on the next edge and queued words are discarded.
- FIFO write: `wr_en` with `wr_ready`=1 stores the word. `wr_en` with FIFO full drops the word and pulses `overflow`, even if a pop happens in the same cycle.
- Simultaneous push and pop with FIFO not full: both take effect and `fifo_count` is unchanged.
- States and transitions:
  - IDLE: `tx`=1. On `tx_en` with FIFO non-empty: pop the word into the shift register, latch `parity_mode` for the whole frame, drive `tx`=0, go to START.
  - START: on `tx_en`, drive data bit 0 and go to DATA with index=1.
  - DATA: on each `tx_en`, if index<DATA_BITS drive bit[index] and increment index. Otherwise drive the parity bit and go to PARITY if parity is enabled, else drive `tx`=1 and go to STOP with stop_cnt=1.
  - PARITY: on `tx_en`, drive `tx`=1 and go to STOP with stop_cnt=1.
  - STOP: on `tx_en` with stop_cnt<STOP_BITS, hold `tx`=1 and increment stop_cnt. Otherwise pulse `frame_done`, then:
    - FIFO non-empty: pop, drive `tx`=0 and go to START (back-to-back frames, no idle gap).
    - FIFO empty: go to IDLE with `tx`=1.
- Parity bit is computed over the DATA_BITS data bits only. Even: XOR of the data bits. Odd: inverted XOR.
- `tx_en` outside IDLE with an empty FIFO has no effect beyond the frame sequence. `wr_en` never disturbs the frame in flight.
- Illegal state encoding: next edge goes to IDLE with `tx`=1.

## Timing
- Every symbol lasts exactly one tick period, from one `tx_en` to the next. `tx` is registered and changes only on `tx_en` cycles (or on reset).
- Frame length in ticks is 1 + DATA_BITS + (parity?1:0) + STOP_BITS.
- Latency from a `wr_en` into an empty, idle block to the start bit is the first `tx_en` at least one cycle after the write. A `tx_en` in the same cycle as `wr_en` does not start the frame.
- `wr_ready`, `fifo_count` and `busy` are registered and reflect the state after the current edge.
- `busy` rises on the same edge that drives the start bit. It falls on the edge that enters IDLE.

## Structure
- Package `uart_pkg`:
  - state enum `tx_state_t` {IDLE, START, DATA, PARITY, STOP}.
  - parity encoding constants `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`.
  - function `calc_parity(data, mode)`.
- Sub-module `uart_sync_fifo`: parametrised by WIDTH and DEPTH, with push/pop/full/empty/count. The FSM, shift register and counters live in the top.

## Test plan
- DATA_BITS=8, even parity, 1 stop: write 0xA5, then tick repeatedly → `tx` symbols 0,1,0,1,0,0,1,0,1,0,1, then `frame_done` pulses and `busy` falls.
- Odd parity, STOP_BITS=2: write 0x00 → 0, eight 0s, parity 1, 1, 1; frame is 12 ticks long.
- FIFO_DEPTH=4: write 0x11,0x22,0x33,0x44,0x55 in consecutive cycles while idle with no ticks → `overflow` pulses on 0x55 only and `fifo_count`=4. Then ticking gives four back-to-back frames with no idle symbol between stop and start.
- `parity_mode` changed from none to even mid-frame → current frame has no parity bit and the next frame has one.
- Assert `rst` during DATA of 0xFF with two words queued → next edge `tx`=1, `busy`=0, `fifo_count`=0. Further ticks keep `tx`=1.
- DATA_BITS=5, no parity: write 0x1F with `tx_en` in the same cycle → start bit appears on the following tick, not that one. Frame is 0,1,1,1,1,1,1.
